// File: rtl/decode_stage.sv
// ID stage of the 16-bit pipelined CPU: registers one {IR, PC} pair, decodes it for EX,
// detects load-use hazards and latches HLT into a sticky halt. Optional macro: ILLEGAL_TRAP_EN.
module decode_stage #(
    parameter int PC_W    = 16,
    parameter int PC_STEP = 2,
    parameter int REG_AW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_ir,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [3:0]        out_opcode,
    output logic [REG_AW-1:0] out_rd,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [15:0]       out_imm,
    output logic [PC_W-1:0]   out_target,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_branch,
    output logic              out_jump,
    output logic              out_halt,
    output logic              out_illegal,
    output logic              stall,
    output logic              halt_program
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_BNE  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_LUI  = 4'hC;
    localparam logic [3:0] OP_RSVD = 4'hD;
    localparam logic [3:0] OP_RSVE = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // Control vector bit order: reg_write, mem_read, mem_write, branch, jump, halt, illegal
    localparam int CTL_W = 7;

    logic [3:0]        op_s;
    logic [15:0]       imm6_s;
    logic [15:0]       imm12_s;
    logic [15:0]       imm_s;
    logic [CTL_W-1:0]  ctl_s;
    logic              uses_rt_s;
    logic              halt_on_s;
    logic [PC_W-1:0]   seq_pc_s;
    logic [PC_W-1:0]   imm_pc_s;
    logic [PC_W-1:0]   target_s;
    logic              stall_s;
    logic              in_ready_s;
    logic              accept_s;

    logic [0:0]        state_r;
    logic              out_valid_r;
    logic [PC_W-1:0]   out_pc_r;
    logic [3:0]        out_opcode_r;
    logic [REG_AW-1:0] out_rd_r;
    logic [REG_AW-1:0] out_rs_r;
    logic [REG_AW-1:0] out_rt_r;
    logic [15:0]       out_imm_r;
    logic [PC_W-1:0]   out_target_r;
    logic [CTL_W-1:0]  ctl_r;

    assign op_s    = in_ir[15:12];
    assign imm6_s  = {{10{in_ir[5]}}, in_ir[5:0]};
    assign imm12_s = {{4{in_ir[11]}}, in_ir[11:0]};

    // Opcode decode into immediate, control vector and rt-usage for hazard detection
    always_comb begin
        imm_s     = 16'h0000;
        ctl_s     = {CTL_W{1'b0}};
        uses_rt_s = 1'b0;
        case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
                ctl_s     = 7'b1000000;
                uses_rt_s = 1'b1;
            end
            OP_ADDI: begin
                ctl_s = 7'b1000000;
                imm_s = imm6_s;
            end
            OP_LW: begin
                ctl_s = 7'b1100000;
                imm_s = imm6_s;
            end
            OP_SW: begin
                ctl_s     = 7'b0010000;
                imm_s     = imm6_s;
                uses_rt_s = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctl_s     = 7'b0001000;
                imm_s     = imm6_s;
                uses_rt_s = 1'b1;
            end
            OP_JMP: begin
                ctl_s = 7'b0000100;
                imm_s = imm12_s;
            end
            OP_LUI: begin
                ctl_s = 7'b1000000;
                imm_s = {in_ir[7:0], 8'h00};
            end
            OP_RSVD, OP_RSVE: begin
                ctl_s = 7'b0000001;
            end
            OP_HLT: begin
                ctl_s = 7'b0000010;
            end
            default: begin
                ctl_s     = {CTL_W{1'b0}};
                imm_s     = 16'h0000;
                uses_rt_s = 1'b0;
            end
        endcase
    end

    // Instructions without an immediate carry imm=0, so the target collapses to pc+step
    assign seq_pc_s = in_pc + PC_W'(PC_STEP);
    assign imm_pc_s = PC_W'($signed(imm_s));
    assign target_s = seq_pc_s + {imm_pc_s[PC_W-2:0], 1'b0};

`ifdef ILLEGAL_TRAP_EN
    assign halt_on_s = ctl_s[1] | ctl_s[0];
`else
    assign halt_on_s = ctl_s[1];
`endif

    assign stall_s = in_valid & ex_mem_read &
                     ((ex_rd == in_ir[8:6]) | ((ex_rd == in_ir[5:3]) & uses_rt_s));

    assign in_ready_s = (state_r == ST_RUN) & ~stall_s & (~out_valid_r | out_ready);
    assign accept_s   = in_valid & in_ready_s & ~flush;

    // Run/halt state: halting is sticky until reset, and a flushed HLT never halts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else if (accept_s & halt_on_s) begin
            state_r <= ST_HALTED;
        end else begin
            state_r <= state_r;
        end
    end

    // Valid and control bits: flush beats accept; a bubble or consumed slot clears control
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            ctl_r       <= {CTL_W{1'b0}};
        end else if (flush) begin
            out_valid_r <= 1'b0;
            ctl_r       <= {CTL_W{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            ctl_r       <= ctl_s;
        end else if (out_valid_r & ~out_ready) begin
            out_valid_r <= out_valid_r;
            ctl_r       <= ctl_r;
        end else begin
            out_valid_r <= 1'b0;
            ctl_r       <= {CTL_W{1'b0}};
        end
    end

    // Data fields only load on accept, staying stable under backpressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_pc_r     <= {PC_W{1'b0}};
            out_opcode_r <= 4'h0;
            out_rd_r     <= {REG_AW{1'b0}};
            out_rs_r     <= {REG_AW{1'b0}};
            out_rt_r     <= {REG_AW{1'b0}};
            out_imm_r    <= 16'h0000;
            out_target_r <= {PC_W{1'b0}};
        end else if (accept_s) begin
            out_pc_r     <= in_pc;
            out_opcode_r <= op_s;
            out_rd_r     <= in_ir[11:9];
            out_rs_r     <= in_ir[8:6];
            out_rt_r     <= in_ir[5:3];
            out_imm_r    <= imm_s;
            out_target_r <= target_s;
        end else begin
            out_pc_r     <= out_pc_r;
            out_opcode_r <= out_opcode_r;
            out_rd_r     <= out_rd_r;
            out_rs_r     <= out_rs_r;
            out_rt_r     <= out_rt_r;
            out_imm_r    <= out_imm_r;
            out_target_r <= out_target_r;
        end
    end

    assign in_ready      = in_ready_s;
    assign stall         = stall_s;
    assign halt_program  = (state_r == ST_HALTED);
    assign out_valid     = out_valid_r;
    assign out_pc        = out_pc_r;
    assign out_opcode    = out_opcode_r;
    assign out_rd        = out_rd_r;
    assign out_rs        = out_rs_r;
    assign out_rt        = out_rt_r;
    assign out_imm       = out_imm_r;
    assign out_target    = out_target_r;
    assign out_reg_write = ctl_r[6];
    assign out_mem_read  = ctl_r[5];
    assign out_mem_write = ctl_r[4];
    assign out_branch    = ctl_r[3];
    assign out_jump      = ctl_r[2];
    assign out_halt      = ctl_r[1];
    assign out_illegal   = ctl_r[0];

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus random traffic against
// an arithmetic reference model of the decode/handshake rules.
module tb_decode_stage;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ir;
    logic [15:0] in_pc;
    logic        ex_mem_read;
    logic [2:0]  ex_rd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [3:0]  out_opcode;
    logic [2:0]  out_rd, out_rs, out_rt;
    logic [15:0] out_imm;
    logic [15:0] out_target;
    logic        out_reg_write, out_mem_read, out_mem_write, out_branch;
    logic        out_jump, out_halt, out_illegal;
    logic        stall;
    logic        halt_program;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic        m_valid, m_halted;
    logic [15:0] m_pc, m_imm, m_tgt;
    logic [3:0]  m_op;
    logic [2:0]  m_rd, m_rs, m_rt;
    logic [6:0]  m_ctl;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ir(in_ir), .in_pc(in_pc), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
        .out_imm(out_imm), .out_target(out_target), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_branch(out_branch), .out_jump(out_jump), .out_halt(out_halt),
        .out_illegal(out_illegal), .stall(stall), .halt_program(halt_program)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sext(input int v, input int bits);
        if (v >= (1 << (bits - 1))) return v - (1 << bits);
        else return v;
    endfunction

    function automatic int imm_of(input int ir);
        int op;
        op = (ir >> 12) & 15;
        if (op >= 6 && op <= 10) return sext(ir & 63, 6);
        if (op == 11) return sext(ir & 4095, 12);
        if (op == 12) return (ir & 255) * 256;
        return 0;
    endfunction

    // {reg_write, mem_read, mem_write, branch, jump, halt, illegal}
    function automatic logic [6:0] ctl_of(input int op);
        logic [6:0] c;
        c[6] = (op <= 7) || (op == 12);
        c[5] = (op == 7);
        c[4] = (op == 8);
        c[3] = (op == 9) || (op == 10);
        c[2] = (op == 11);
        c[1] = (op == 15);
        c[0] = (op == 13) || (op == 14);
        return c;
    endfunction

    function automatic bit uses_rt(input int op);
        return (op <= 5) || (op == 8) || (op == 9) || (op == 10);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_halted = 1'b0; m_pc = 16'h0000; m_imm = 16'h0000;
        m_tgt = 16'h0000; m_op = 4'h0; m_rd = 3'd0; m_rs = 3'd0; m_rt = 3'd0;
        m_ctl = 7'd0;
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, m_valid);
        check("halt_program", halt_program, m_halted);
        check("ctl", {out_reg_write, out_mem_read, out_mem_write, out_branch,
                      out_jump, out_halt, out_illegal}, m_ctl);
        if (m_valid) begin
            check("out_pc", out_pc, m_pc);
            check("out_opcode", out_opcode, m_op);
            check("out_regs", {out_rd, out_rs, out_rt}, {m_rd, m_rs, m_rt});
            check("out_imm", out_imm, m_imm);
            check("out_target", out_target, m_tgt);
        end
    endtask

    // one clock cycle: drive, check combinational outputs, advance model, check registers
    task automatic step(input logic v, input logic [15:0] ir, input logic [15:0] pc,
                        input logic fl, input logic emr, input logic [2:0] erd,
                        input logic ordy, output logic obs_stall, output logic obs_ready);
        int  op, imm;
        bit  e_stall, e_ready;
        @(negedge clk);
        in_valid = v; in_ir = ir; in_pc = pc; flush = fl;
        ex_mem_read = emr; ex_rd = erd; out_ready = ordy;
        #1;
        op = int'(ir[15:12]);
        e_stall = v && emr && ((erd == ir[8:6]) || ((erd == ir[5:3]) && uses_rt(op)));
        e_ready = !m_halted && !e_stall && (!m_valid || ordy);
        obs_stall = stall;
        obs_ready = in_ready;
        check("stall", stall, e_stall);
        check("in_ready", in_ready, e_ready);
        if (fl) begin
            m_valid = 1'b0; m_ctl = 7'd0;
        end else if (v && e_ready) begin
            imm     = imm_of(int'(ir));
            m_valid = 1'b1;
            m_pc    = pc;
            m_op    = ir[15:12];
            m_rd    = ir[11:9]; m_rs = ir[8:6]; m_rt = ir[5:3];
            m_imm   = 16'(imm);
            m_tgt   = 16'((int'(pc) + 2 + 2 * imm) & 16'hFFFF);
            m_ctl   = ctl_of(op);
            if (op == 15 || (TRAP && (op == 13 || op == 14))) m_halted = 1'b1;
        end else if (m_valid && !ordy) begin
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0; m_ctl = 7'd0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // async reset asserted mid-cycle: outputs must clear without a clock edge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid", out_valid, 32'd0);
        check("rst_halt", halt_program, 32'd0);
        check("rst_ctl", {out_reg_write, out_mem_read, out_mem_write, out_branch,
                          out_jump, out_halt, out_illegal}, 32'd0);
        model_reset();
        in_valid = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_ready", in_ready, 32'd1);
    endtask

    initial begin
        logic s, r;
        logic [15:0] ir;
        int op;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ir = 16'h0000; in_pc = 16'h0000;
        ex_mem_read = 1'b0; ex_rd = 3'd0; out_ready = 1'b1;
        model_reset();
        #2 rst = 1'b0;
        #1;
        check("por_valid", out_valid, 32'd0);
        check("por_pc", out_pc, 32'd0);
        do_reset();

        // LW r1,[r2+3]
        step(1'b1, 16'h7283, 16'h0010, 1'b0, 1'b0, 3'd0, 1'b1, s, r);
        check("lw_mem_read", out_mem_read, 32'd1);
        check("lw_rd_rs", {out_rd, out_rs}, {3'd1, 3'd2});
        check("lw_imm", out_imm, 32'h0003);
        check("lw_reg_write", out_reg_write, 32'd1);

        // BEQ imm=-2
        step(1'b1, 16'h9A3E, 16'h0040, 1'b0, 1'b0, 3'd0, 1'b1, s, r);
        check("beq_branch", out_branch, 32'd1);
        check("beq_imm", out_imm, 32'hFFFE);
        check("beq_target", out_target, 32'h003E);

        // load-use on rt: bubble, then accepted once the load leaves EX
        step(1'b1, 16'h0250, 16'h0100, 1'b0, 1'b1, 3'd2, 1'b1, s, r);
        check("hz_stall", s, 32'd1);
        check("hz_ready", r, 32'd0);
        check("hz_bubble", out_valid, 32'd0);
        step(1'b1, 16'h0250, 16'h0100, 1'b0, 1'b0, 3'd2, 1'b1, s, r);
        check("hz_accept", out_valid, 32'd1);
        check("hz_pc", out_pc, 32'h0100);

        // backpressure for three cycles
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h1111, 16'h0200, 1'b0, 1'b0, 3'd0, 1'b0, s, r);
            check("bp_ready", r, 32'd0);
            check("bp_pc", out_pc, 32'h0100);
        end
        step(1'b1, 16'h1111, 16'h0200, 1'b0, 1'b0, 3'd0, 1'b1, s, r);
        check("bp_release", out_pc, 32'h0200);

        // flush + HLT: HLT dropped
        step(1'b1, 16'hF000, 16'h0300, 1'b1, 1'b0, 3'd0, 1'b1, s, r);
        check("fl_hlt_halt", halt_program, 32'd0);
        check("fl_hlt_valid", out_valid, 32'd0);

        // wrap-around target: JMP -1 from 0xFFFE
        step(1'b1, 16'hBFFF, 16'hFFFE, 1'b0, 1'b0, 3'd0, 1'b1, s, r);
        check("wrap_target", out_target, 32'hFFFE);

        // HLT halts forever
        step(1'b1, 16'hF000, 16'h0400, 1'b0, 1'b0, 3'd0, 1'b1, s, r);
        check("hlt_out", out_halt, 32'd1);
        check("hlt_sticky", halt_program, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h6041, 16'h0402, 1'b0, 1'b0, 3'd0, 1'b1, s, r);
            check("hlt_ready", r, 32'd0);
        end
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b1, s, r);
        check("hlt_flush", halt_program, 32'd1);

        // reserved opcode
        do_reset();
        step(1'b1, 16'hD000, 16'h0500, 1'b0, 1'b0, 3'd0, 1'b0, s, r);
        check("rsv_illegal", out_illegal, 32'd1);
        check("rsv_halt", halt_program, 32'(TRAP));
        do_reset();

        // random traffic, reset between rounds (reset lands while out_valid may be 1)
        for (int round = 0; round < 4; round++) begin
            for (int c = 0; c < 500; c++) begin
                op = ($urandom_range(0, 79) == 0) ? 15 : int'($urandom_range(0, 14));
                ir = 16'($urandom);
                ir[15:12] = 4'(op);
                step(1'($urandom_range(0, 3) != 0), ir, {15'($urandom), 1'b0},
                     1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0),
                     3'($urandom), 1'($urandom_range(0, 3) != 0), s, r);
            end
            do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
